screen_sequencer: RTL and testbench

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_sequencer_pkg.sv | 51 +++++
 rtl/screen_sequencer_if.sv | 29 ++
 rtl/screen_sequencer_frame_tick_gen.sv | 32 +++
 rtl/screen_sequencer.sv | 168 ++++++++++++++++
 tb/tb_screen_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_sequencer_pkg.sv
// Shared types and default constants for the screen sequencer.
package screen_pkg;

  // Top-level screen states.
  typedef enum logic [2:0] {
    ST_FADE   = 3'd0,
    ST_TITLE  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_PLAY   = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // Default parameter values.
  localparam logic [7:0] DEF_START_KEY        = 8'h28;
  localparam int         DEF_FADE_STEP_FRAMES = 4;
  localparam int         DEF_BLINK_FRAMES     = 30;
  localparam int         DEF_GAMEOVER_FRAMES  = 180;
  localparam int         DEF_START_LIVES      = 3;

  // Width of the shared per-state frame counter.
  localparam int         FRAME_CNT_W          = 16;

  // Full title brightness.
  localparam logic [3:0] FADE_FULL            = 4'd15;

  // Renderer enables and launch pulse, one bundle per state.
  typedef struct packed {
    logic start_screen;
    logic game_active;
    logic game_over;
    logic game_reset;
  } screen_en_t;

  // Enables seen while held in reset (title path).
  localparam screen_en_t EN_RESET = '{start_screen: 1'b1, default: 1'b0};

  // Map a state to the enables it drives.
  function automatic screen_en_t state_enables(input state_e s);
    screen_en_t en;
    en = '0;
    case (s)
      ST_FADE, ST_TITLE: en.start_screen = 1'b1;
      ST_LAUNCH:         en.game_reset   = 1'b1;
      ST_PLAY:           en.game_active  = 1'b1;
      ST_OVER:           en.game_over    = 1'b1;
      default:           en              = EN_RESET;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Bus between the VGA/game side and the screen sequencer.
interface screen_sequencer_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [7:0] keycode;
  logic       player_dead;
  logic       start_screen;
  logic       game_active;
  logic       game_over;
  logic       game_reset;
  logic       text_blink;
  logic [3:0] fade_level;
  logic [1:0] lives_left;
  logic       frame_tick;

  // System side: supplies raster position, keys and deaths.
  modport master (
    output DrawX, DrawY, keycode, player_dead,
    input  start_screen, game_active, game_over, game_reset,
    input  text_blink, fade_level, lives_left, frame_tick
  );

  // Sequencer side.
  modport slave (
    input  DrawX, DrawY, keycode, player_dead,
    output start_screen, game_active, game_over, game_reset,
    output text_blink, fade_level, lives_left, frame_tick
  );
endinterface

// File: rtl/screen_sequencer_frame_tick_gen.sv
// One-cycle frame pulse when the raster position arrives at (0,0).
module frame_tick_gen
  import screen_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       frame_tick
);

  logic at_origin;
  logic origin_q;
  logic tick_q;

  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Edge-detect entry into (0,0); out of reset we treat the position as
  // already at the origin so a reset release alone never produces a tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      origin_q <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      origin_q <= at_origin;
      tick_q   <= at_origin & ~origin_q;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen flow controller: fade-in, title, launch, play, game over.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter logic [7:0] START_KEY        = DEF_START_KEY,
  parameter int         FADE_STEP_FRAMES = DEF_FADE_STEP_FRAMES,
  parameter int         BLINK_FRAMES     = DEF_BLINK_FRAMES,
  parameter int         GAMEOVER_FRAMES  = DEF_GAMEOVER_FRAMES,
  parameter int         START_LIVES      = DEF_START_LIVES
) (
  input logic               vga_clk,
  input logic               reset_n,
  screen_sequencer_if.slave bus
);

  localparam logic [FRAME_CNT_W-1:0] FADE_STEP_CNT = FRAME_CNT_W'(FADE_STEP_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLINK_CNT     = FRAME_CNT_W'(BLINK_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] OVER_CNT      = FRAME_CNT_W'(GAMEOVER_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE       = FRAME_CNT_W'(1);
  localparam logic [1:0]             LIVES_INIT    = 2'(START_LIVES);

  state_e                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAME_CNT_W-1:0] cnt_inc;
  logic [3:0]             fade_q, fade_d;
  logic                   blink_q, blink_d;
  logic [1:0]             lives_q, lives_d;
  logic                   armed_q, armed_d;
  logic [7:0]             key_prev_q;
  screen_en_t             en_q;
  logic                   frame_tick;
  logic                   key_is_start;
  logic                   start_press;

  frame_tick_gen u_tick (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (bus.DrawX),
    .DrawY      (bus.DrawY),
    .frame_tick (frame_tick)
  );

  assign key_is_start = (bus.keycode == START_KEY);
  assign start_press  = key_is_start && (key_prev_q != START_KEY);
  assign cnt_inc      = cnt_q + CNT_ONE;

  // Next-state, counter, fade, blink, lives and arming decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fade_d  = fade_q;
    blink_d = blink_q;
    lives_d = lives_q;
    armed_d = armed_q;

    case (state_q)
      ST_FADE: begin
        // Presses are ignored here and never arm the title.
        if (frame_tick) begin
          if (cnt_inc == FADE_STEP_CNT) begin
            cnt_d = '0;
            if (fade_q == FADE_FULL) begin
              state_d = ST_TITLE;
            end else begin
              fade_d = fade_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_TITLE: begin
        fade_d = FADE_FULL;
        if (!key_is_start) begin
          armed_d = 1'b1;
        end
        if (start_press && armed_q) begin
          state_d = ST_LAUNCH;
        end else if (frame_tick) begin
          if (cnt_inc == BLINK_CNT) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_LAUNCH: begin
        state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (bus.player_dead) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
          end else begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end
        end
      end

      ST_OVER: begin
        if (frame_tick) begin
          if (cnt_inc == OVER_CNT) begin
            state_d = ST_FADE;
            fade_d  = 4'd0;
            blink_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = ST_FADE;
        fade_d  = 4'd0;
        blink_d = 1'b0;
      end
    endcase

    // Every state starts its count from zero; a tick landing on the
    // transition is swallowed. Arming is only meaningful inside one TITLE visit.
    if (state_d != state_q) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end

    if (state_d == ST_LAUNCH) begin
      lives_d = LIVES_INIT;
    end
  end

  // State and output registers; enables follow the state being entered.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FADE;
      cnt_q      <= '0;
      fade_q     <= 4'd0;
      blink_q    <= 1'b0;
      lives_q    <= 2'd0;
      armed_q    <= 1'b0;
      key_prev_q <= 8'h00;
      en_q       <= EN_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fade_q     <= fade_d;
      blink_q    <= blink_d;
      lives_q    <= lives_d;
      armed_q    <= armed_d;
      key_prev_q <= bus.keycode;
      en_q       <= state_enables(state_d);
    end
  end

  assign bus.start_screen = en_q.start_screen;
  assign bus.game_active  = en_q.game_active;
  assign bus.game_over    = en_q.game_over;
  assign bus.game_reset   = en_q.game_reset;
  assign bus.text_blink   = blink_q;
  assign bus.fade_level   = fade_q;
  assign bus.lives_left   = lives_q;
  assign bus.frame_tick   = frame_tick;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a cycle-level reference model.
`timescale 1ns/1ps
module tb_screen_sequencer;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam int FADE_STEP = 4;
  localparam int BLINK     = 30;
  localparam int OVER_FR   = 180;
  localparam int LIVES0    = 3;
  localparam int FRAME_LEN = 8;

  localparam int M_FADE = 0, M_TITLE = 1, M_LAUNCH = 2, M_PLAY = 3, M_OVER = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] gen_x;
  logic [9:0] man_x, man_y;
  logic       man_mode;
  logic [7:0] key;
  logic       dead;

  int errors = 0;
  int checks = 0;
  int grst_seen = 0;

  screen_sequencer_if bus();

  assign bus.DrawX       = man_mode ? man_x : gen_x;
  assign bus.DrawY       = man_mode ? man_y : 10'd0;
  assign bus.keycode     = key;
  assign bus.player_dead = dead;

  screen_sequencer #(
    .START_KEY        (KEY_ENTER),
    .FADE_STEP_FRAMES (FADE_STEP),
    .BLINK_FRAMES     (BLINK),
    .GAMEOVER_FRAMES  (OVER_FR),
    .START_LIVES      (LIVES0)
  ) dut (
    .vga_clk (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- reference model ----------------
  int   m_mode, m_frames, m_fade, m_blink, m_lives;
  bit   m_armed, m_prev_org, m_tick;
  logic [7:0] m_prevkey;

  task automatic model_reset();
    m_mode = M_FADE; m_frames = 0; m_fade = 0; m_blink = 0; m_lives = 0;
    m_armed = 0; m_prev_org = 1; m_tick = 0; m_prevkey = 8'h00;
  endtask

  task automatic model_step();
    bit t, press, org;
    if (!reset_n) begin
      model_reset();
      return;
    end
    t     = m_tick;
    press = (bus.keycode == KEY_ENTER) && (m_prevkey != KEY_ENTER);
    org   = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
    case (m_mode)
      M_FADE: if (t) begin
        m_frames++;
        if (m_frames == 16 * FADE_STEP) begin
          m_mode = M_TITLE; m_frames = 0; m_armed = 0;
        end
      end
      M_TITLE: begin
        if (press && m_armed) begin
          m_mode = M_LAUNCH; m_lives = LIVES0;
        end else begin
          if (t) m_frames++;
          if (bus.keycode != KEY_ENTER) m_armed = 1;
        end
      end
      M_LAUNCH: m_mode = M_PLAY;
      M_PLAY: if (bus.player_dead) begin
        if (m_lives > 1) m_lives--;
        else begin m_lives = 0; m_mode = M_OVER; m_frames = 0; end
      end
      default: if (t) begin
        m_frames++;
        if (m_frames == OVER_FR) begin
          m_mode = M_FADE; m_frames = 0; m_blink = 0;
        end
      end
    endcase
    if (m_mode == M_FADE)  m_fade = (m_frames / FADE_STEP > 15) ? 15 : m_frames / FADE_STEP;
    if (m_mode == M_TITLE) begin
      m_fade  = 15;
      m_blink = (m_frames / BLINK) % 2;
    end
    m_tick     = org && !m_prev_org;
    m_prev_org = org;
    m_prevkey  = bus.keycode;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic [12:0] act, exp;
    act = {bus.start_screen, bus.game_active, bus.game_over, bus.game_reset,
           bus.text_blink, bus.fade_level, bus.lives_left, bus.frame_tick};
    exp = {(m_mode == M_FADE || m_mode == M_TITLE), (m_mode == M_PLAY), (m_mode == M_OVER),
           (m_mode == M_LAUNCH), m_blink[0], 4'(m_fade), 2'(m_lives), m_tick};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cmp at %0t: got ss/ga/go/gr/blk/fade/lives/tick=%b expected %b",
               $time, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (bus.frame_tick !== 1'b1 && guard < 100);
      if (bus.frame_tick !== 1'b1) begin
        chk("tick_timeout", 0, 1);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_screen"}, int'(bus.start_screen), 1);
    chk({tag, "_game_active"},  int'(bus.game_active), 0);
    chk({tag, "_game_over"},    int'(bus.game_over), 0);
    chk({tag, "_game_reset"},   int'(bus.game_reset), 0);
    chk({tag, "_fade"},         int'(bus.fade_level), 0);
    chk({tag, "_blink"},        int'(bus.text_blink), 0);
    chk({tag, "_lives"},        int'(bus.lives_left), 0);
    chk({tag, "_tick"},         int'(bus.frame_tick), 0);
  endtask

  // Free-running short raster: (0,0) once every FRAME_LEN cycles.
  initial begin
    gen_x = 10'd1;
    forever begin
      @(posedge clk); #1;
      gen_x = (gen_x == 10'(FRAME_LEN - 1)) ? 10'd0 : gen_x + 10'd1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [6:0] pat;
    int grst_before;
    key = 8'h00; dead = 1'b0; man_mode = 1'b0; man_x = 10'd0; man_y = 10'd0;

    fork
      forever begin
        @(negedge clk);
        compare_cycle();
        if (bus.game_reset === 1'b1) grst_seen++;
      end
    join_none

    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Fade-in: level = frames/4, full at 60, TITLE on 64.
    wait_ticks(4);  chk("fade_after_4", int'(bus.fade_level), 1);
    wait_ticks(55); chk("fade_after_59", int'(bus.fade_level), 14);
    wait_ticks(1);  chk("fade_after_60", int'(bus.fade_level), 15);
    wait_ticks(1);
    key = KEY_ENTER;                       // pressed during FADE, held into TITLE
    wait_ticks(2);  chk("fade_after_63", int'(bus.fade_level), 15);
    wait_ticks(1);  chk("title_ss", int'(bus.start_screen), 1);
    dead = 1'b1; step(); dead = 1'b0;      // death outside PLAY is ignored
    chk("title_dead_ignored", int'(bus.lives_left), 0);

    // Blink toggles every 30 frames counted from TITLE entry at frame 64.
    wait_ticks(29); chk("blink_t29", int'(bus.text_blink), 0);
    wait_ticks(1);  chk("blink_t30", int'(bus.text_blink), 1);
    wait_ticks(29); chk("blink_t59", int'(bus.text_blink), 1);
    wait_ticks(1);  chk("blink_t60", int'(bus.text_blink), 0);
    wait_ticks(30); chk("blink_t90", int'(bus.text_blink), 1);
    chk("held_enter_no_launch", grst_seen, 0);
    chk("held_enter_not_active", int'(bus.game_active), 0);

    // Release then press: single launch pulse, then play.
    key = 8'h00; step();
    key = KEY_ENTER; step();
    chk("launch_game_reset", int'(bus.game_reset), 1);
    chk("launch_lives", int'(bus.lives_left), 3);
    chk("launch_ss_off", int'(bus.start_screen), 0);
    chk("launch_ga_off", int'(bus.game_active), 0);
    step();
    chk("play_game_reset_low", int'(bus.game_reset), 0);
    chk("play_active", int'(bus.game_active), 1);
    key = 8'h00; step();
    key = KEY_ENTER; step();               // keys ignored while playing
    key = 8'h00; step();
    chk("play_key_ignored", grst_seen, 1);

    // Three deaths: 2, 1, 0 and OVER.
    for (int k = 0; k < 3; k++) begin
      dead = 1'b1; step(); dead = 1'b0;
      chk("lives_after_death", int'(bus.lives_left), 2 - k);
      chk("over_after_death", int'(bus.game_over), (k == 2) ? 1 : 0);
      step();
    end
    chk("over_ga_off", int'(bus.game_active), 0);
    dead = 1'b1; step(); dead = 1'b0;      // ignored in OVER
    chk("over_dead_ignored", int'(bus.lives_left), 0);

    wait_ticks(OVER_FR - 1); chk("over_held_179", int'(bus.game_over), 1);
    wait_ticks(1);
    chk("over_exit_ss", int'(bus.start_screen), 1);
    chk("over_exit_fade", int'(bus.fade_level), 0);
    chk("over_exit_blink", int'(bus.text_blink), 0);
    chk("over_exit_go", int'(bus.game_over), 0);

    // Origin held for 5 cycles: one tick, in the cycle after arrival.
    man_x = 10'd3; man_y = 10'd3; man_mode = 1'b1;
    repeat (3) step();
    man_x = 10'd0; man_y = 10'd0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin man_x = 10'd3; man_y = 10'd3; end
      @(negedge clk);
      pat[i] = bus.frame_tick;
      step();
    end
    chk("origin_hold_pattern", int'(pat), 2);
    man_mode = 1'b0;

    // Back to PLAY, then reset mid-game.
    wait_ticks(64);
    key = KEY_ENTER; step();
    chk("relaunch_game_reset", int'(bus.game_reset), 1);
    key = 8'h00; step();
    dead = 1'b1; step(); dead = 1'b0;
    chk("replay_lives", int'(bus.lives_left), 2);
    grst_before = grst_seen;
    @(posedge clk); #2;
    reset_n = 1'b0; #1;
    chk_reset_outputs("async_reset");
    repeat (3) step();
    reset_n = 1'b1;
    step(); step();
    chk("post_reset_ss", int'(bus.start_screen), 1);
    chk("post_reset_fade", int'(bus.fade_level), 0);
    chk("post_reset_active", int'(bus.game_active), 0);
    chk("no_reset_launch", grst_seen, grst_before);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
